// File: rtl/mspu_uart_pkg.sv
// Shared types and constants for the board-level UART transmit path.
package mspu_uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: accepts one byte in IDLE and shifts it out LSB first at
// CLKS_PER_BIT clocks per bit.
module uart_tx_serializer
    import mspu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [UART_DATA_BITS-1:0] in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      uart_tx
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_tx_state_t            state_q, state_d;
    logic [CntW-1:0]           baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tc;

    assign tc = (baud_q == CntW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d = in_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tc) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (tc) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (tc) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line is driven from registered state only, so async reset forces it high at once.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        uart_tx  = 1'b1;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StStart: uart_tx = 1'b0;
            StData:  uart_tx = shift_q[0];
            StStop:  uart_tx = 1'b1;
            default: uart_tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of a single 8N1 UART
// transmitter shared by NUM_REQ byte-stream requesters.
module uart_tx_arbiter
    import mspu_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ-1:0][UART_DATA_BITS-1:0]        req_data,
    input  logic [NUM_REQ-1:0]                            req_last,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic [$clog2(NUM_REQ)-1:0]                    grant_id,
    output logic                                          locked,
    output logic                                          busy,
    output logic                                          uart_tx
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic           locked_q, locked_d;

    logic [IdW:0]   cand;
    logic [IdW-1:0] pick, sel;
    logic           any_valid, sel_valid, ser_ready, accept;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        cand      = '0;
        pick      = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IdW + 1)'(i);
            if (cand >= (IdW + 1)'(NUM_REQ)) begin
                cand = cand - (IdW + 1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[cand[IdW-1:0]]) begin
                any_valid = 1'b1;
                pick      = cand[IdW-1:0];
            end
        end
    end

    assign sel       = locked_q ? grant_q : pick;
    assign sel_valid = locked_q ? req_valid[grant_q] : any_valid;
    assign accept    = sel_valid && ser_ready;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        if (accept) begin
            grant_d  = sel;
            locked_d = !req_last[sel];
            if (req_last[sel]) begin
                ptr_d = (sel == IdW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
        end
    end

    assign grant_id = grant_q;
    assign locked   = locked_q;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .in_valid(sel_valid),
        .in_data (req_data[sel]),
        .in_ready(ser_ready),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with 4 requesters and
// 4 clocks per UART bit.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned CPB = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0][7:0]  req_data;
    logic [NR-1:0]       req_last;
    logic [NR-1:0]       req_ready;
    logic [1:0]          grant_id;
    logic                locked;
    logic                busy;
    logic                uart_tx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .grant_id (grant_id),
        .locked   (locked),
        .busy     (busy),
        .uart_tx  (uart_tx)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic capture_frame(output logic [39:0] s, output int rdy);
        rdy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            s[k] = uart_tx;
            if (req_ready != '0) rdy++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [9:0]  exp_bits;
        logic [39:0] s;
        int          rdy;
        exp_bits = 10'b1_1010_0101_0;   // stop, 0xA5 MSB..LSB, start
        step();
        req_valid   = 4'b0100;
        req_data[2] = 8'hA5;
        req_last[2] = 1'b1;
        wait_ready(5);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_locked got=%b exp=0", locked); end
        capture_frame(s, rdy);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (s[4*b +: 4] !== {4{exp_bits[b]}}) begin
                errors++;
                $display("FAIL single_bit%0d got=%b exp=%b", b, s[4*b +: 4], {4{exp_bits[b]}});
            end
        end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL single_ready_in_frame got=%0d exp=0", rdy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx got=%b exp=1", uart_tx); end
    endtask

    task automatic test_round_robin();
        int ids[4];
        int t[4];
        int n = 0;
        int oh_err = 0;
        for (int i = 0; i < 4; i++) begin ids[i] = -1; t[i] = -1000; end
        do_reset();
        step();
        req_valid = 4'b1011;
        req_last  = 4'b1111;
        req_data  = {8'h03, 8'h02, 8'h01, 8'h00};
        for (int cyc = 0; cyc < 250 && n < 4; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (!$onehot(req_ready)) oh_err++;
                for (int i = 0; i < 4; i++) if (req_ready[i]) ids[n] = i;
                t[n] = cyc;
                n++;
            end
        end
        step();
        req_valid = '0;
        checks++; if (ids[0] !== 0) begin errors++; $display("FAIL rr_grant0 got=%0d exp=0", ids[0]); end
        checks++; if (ids[1] !== 1) begin errors++; $display("FAIL rr_grant1 got=%0d exp=1", ids[1]); end
        checks++; if (ids[2] !== 3) begin errors++; $display("FAIL rr_grant2 got=%0d exp=3", ids[2]); end
        checks++; if (ids[3] !== 0) begin errors++; $display("FAIL rr_grant3 got=%0d exp=0", ids[3]); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (t[i+1] - t[i] !== 41) begin
                errors++;
                $display("FAIL rr_spacing%0d got=%0d exp=41", i, t[i+1] - t[i]);
            end
        end
        checks++; if (oh_err !== 0) begin errors++; $display("FAIL rr_onehot got=%0d exp=0", oh_err); end
        wait_idle();
    endtask

    task automatic test_lock();
        do_reset();
        step();
        req_valid   = 4'b0010;
        req_data[1] = 8'h10;
        req_last[1] = 1'b0;
        wait_ready(5);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_b0 got=%b exp=0010", req_ready); end
        step();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_set got=%b exp=1", locked); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL lock_grant got=%0d exp=1", grant_id); end
        req_valid   = 4'b0011;
        req_data[0] = 8'hEE;
        req_last[0] = 1'b1;
        req_data[1] = 8'h11;
        wait_ready(60);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_b1 got=%b exp=0010", req_ready); end
        step();
        req_data[1] = 8'h12;
        req_last[1] = 1'b1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_held got=%b exp=1", locked); end
        wait_ready(60);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_b2 got=%b exp=0010", req_ready); end
        step();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_release got=%b exp=0", locked); end
        req_valid = 4'b0001;
        wait_ready(60);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lock_req0 got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL lock_grant0 got=%0d exp=0", grant_id); end
    endtask

    task automatic test_stall();
        int rdy = 0;
        int low = 0;
        wait_idle();
        step();
        req_valid   = 4'b0100;
        req_data[2] = 8'h21;
        req_last[2] = 1'b0;
        wait_ready(5);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_first got=%b exp=0100", req_ready); end
        step();
        req_valid   = 4'b1000;
        req_data[3] = 8'h33;
        req_last[3] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready != '0) rdy++;
            if (k >= 45 && uart_tx !== 1'b1) low++;
        end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL stall_ready got=%0d exp=0", rdy); end
        checks++; if (low !== 0) begin errors++; $display("FAIL stall_line_low got=%0d exp=0", low); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stall_locked got=%b exp=1", locked); end
        req_valid   = 4'b1100;
        req_data[2] = 8'h22;
        req_last[2] = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_resume got=%b exp=0100", req_ready); end
        step();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stall_unlock got=%b exp=0", locked); end
        req_valid = 4'b1000;
        wait_ready(60);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_req3 got=%b exp=1000", req_ready); end
        step();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        req_valid   = 4'b1000;
        req_data[3] = 8'h77;
        req_last[3] = 1'b1;
        wait_ready(5);
        step();
        req_valid = '0;
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL wrap_grant3 got=%0d exp=3", grant_id); end
        wait_idle();
        step();
        req_valid   = 4'b1001;
        req_data[0] = 8'h01;
        req_last[0] = 1'b1;
        wait_ready(5);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_next got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL wrap_grant0 got=%0d exp=0", grant_id); end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0]  exp_bits;
        logic [39:0] exp_s;
        logic [39:0] s;
        int          rdy;
        step();
        req_valid   = 4'b1000;
        req_data[3] = 8'h5A;
        req_last[3] = 1'b0;
        wait_ready(5);
        step();
        req_valid = '0;
        repeat (21) @(negedge clk);   // lands in DATA bit 4
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_locked_pre got=%b exp=1", locked); end
        reset = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL mid_tx got=%b exp=1", uart_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got=%b exp=0", locked); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant got=%0d exp=0", grant_id); end
        @(negedge clk);
        reset = 1'b1;
        step();
        req_valid   = 4'b0010;
        req_data[1] = 8'h3C;
        req_last[1] = 1'b1;
        wait_ready(5);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_after_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        exp_bits  = 10'b1_0011_1100_0;   // stop, 0x3C MSB..LSB, start
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) exp_s[4*b + j] = exp_bits[b];
        end
        capture_frame(s, rdy);
        checks++; if (s !== exp_s) begin errors++; $display("FAIL mid_after_frame got=%h exp=%h", s, exp_s); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL mid_after_grant got=%0d exp=1", grant_id); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stall();
        test_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single board-level UART transmit pin among `NUM_REQ` byte-stream requesters (debug printf, trace dump, status reporter, ...). Round-robin arbitration with packet locking keeps multi-byte messages contiguous, and an integrated 8N1 serializer drives `uart_tx`. Sits directly below the top level, between core-side message sources and the `uart_tx` pad.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); minimum 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_data[i]`.
- `req_data`  in  NUM_REQ x 8  byte per requester.
- `req_last`  in  NUM_REQ  byte is the last of its packet; releases the lock.
- `req_ready`  out  NUM_REQ  byte accepted from requester i this cycle; one-hot or zero.
- `grant_id`  out  $clog2(NUM_REQ)  current/last granted requester.
- `locked`  out  1  a packet is in progress; grant held.
- `busy`  out  1  serializer is shifting a frame.
- `uart_tx`  out  1  serial output; idle high.

## Operation
- Reset values: `uart_tx`=1, `req_ready`=0, `grant_id`=0, `locked`=0, `busy`=0, RR pointer=0, bit/baud counters=0, state IDLE.
- FSM (serializer): IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: acceptance cycle (see below). On accept, latch byte and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; 3-bit index, advance on baud-counter terminal count.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- Acceptance (IDLE only, combinational `req_ready`):
  - `locked`=1: accept only from `grant_id`, when its `req_valid`=1; other requesters wait even if valid.
  - `locked`=0: pick first valid requester starting at RR pointer, wrapping modulo NUM_REQ; set `grant_id` to it.
  - On accept: `locked` <= !`req_last[grant]`; if `req_last`, RR pointer <= grant+1 (wrapping at NUM_REQ, not at power of two).
  - No valid requester: remain IDLE, `req_ready`=0.
- Lock has no timeout: a locked owner that deasserts `req_valid` stalls the link until it resumes.
- `req_ready` never asserts outside IDLE; `busy`=1 in START/DATA/STOP.
- `req_data`/`req_last` are sampled only in the accept cycle; later changes do not affect the frame in flight.
- Reset mid-frame: `uart_tx` returns high immediately (async), lock and pointer cleared; a truncated frame on the line is acceptable.

## Timing
- Accept at rising edge N -> `uart_tx` falls after edge N (START entered), `busy`=1 from the same edge.
- Frame = 10*CLKS_PER_BIT cycles in START..STOP; IDLE lasts at least 1 cycle; back-to-back byte period = 10*CLKS_PER_BIT+1 cycles.
- `grant_id` and `locked` update on the accept edge; `grant_id` holds its value through IDLE until the next grant.
- Baud counter counts 0..CLKS_PER_BIT-1, resets to 0 on each state/bit transition.

## Structure
- Package `mspu_uart_pkg`: `uart_tx_state_t` enum (IDLE, START, DATA, STOP), `UART_DATA_BITS`=8, `UART_FRAME_BITS`=10.
- Sub-module `uart_tx_serializer`: FSM, baud counter, shift register; ports `clk`, `reset`, `in_valid`, `in_data`, `in_ready`, `busy`, `uart_tx`. The arbiter (RR pointer, lock, grant mux) stays in `uart_tx_arbiter`.

## Test plan
Bench uses CLKS_PER_BIT=4, NUM_REQ=4.
- Single byte 0xA5, last=1, from req 2 -> `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit (40 cycles); `req_ready[2]` one pulse; `locked` stays 0.
- Reqs 0,1,3 valid simultaneously with single-byte packets, pointer 0 -> grant order 0,1,3, then 0 again; each accept 41 cycles apart.
- Req 1 sends 3-byte packet (0x10,0x11,0x12, last on third) while req 0 holds valid -> all three req-1 bytes sent before any req-0 byte; `locked`=1 until third accept.
- Locked req 2 drops valid for 100 cycles mid-packet while req 3 is valid -> `uart_tx` stays high, no `req_ready[3]`; resumes with req 2.
- Assert `reset` low during DATA bit 4 -> `uart_tx`=1, `busy`=0, `locked`=0, `grant_id`=0 immediately; after release, next valid byte transmits cleanly.
- Pointer wrap: grant req 3 with last=1, then reqs 0 and 3 valid -> req 0 granted next.
